am_insert_tx: RTL and testbench
===============================

# am_insert_tx

Transmit-side alignment marker inserter for one PCS lane of the 40GBASE-R multi-lane datapath. It sits between the lane scrambler output and the lane gearbox. It replaces one 66-bit block slot with the lane's alignment marker every 16384 blocks, stalling the upstream scrambler for that slot. It also computes the BIP3/BIP7 parity fields that the receive-side marker lock and deskew logic check.

## Interface
Parameters:
- BLOCK_W, 66, block width including 2-bit sync header.
- LANE, 0, PCS lane index 0..3; selects the marker bytes.
- GAP_N, 16383, data blocks between consecutive markers.

Ports:
- clk  in  1  clock; one clock, all logic on posedge.
- nreset  in  1  reset, synchronous, active-low.
- valid_i  in  1  block slot enable from the gearbox side; the datapath advances only when 1.
- block_i  in  BLOCK_W  scrambled block from upstream; bits [1:0] are the sync header.
- ready_o  out  1  block_i is consumed this cycle (valid_i & ready_o); combinational from state.
- valid_o  out  1  registered; block_o is valid.
- block_o  out  BLOCK_W  registered output block (data or marker).
- am_v_o  out  1  registered; block_o is a marker.

## Operation
- Slot counter cnt_q, $clog2(GAP_N+1) bits; advances only on valid_i.
  - cnt_q==0 is a marker slot.
  - cnt_q wraps from GAP_N to 0.
  - Reset value 0, so the first valid slot after reset is a marker.
- ready_o = nreset & (cnt_q != 0); it does not depend on valid_i.
- Data slot (valid_i & cnt_q!=0): block_i is forwarded unmodified; cnt_q increments.
- Marker slot (valid_i & cnt_q==0): block_i is not consumed (upstream holds it); cnt_q goes to 1.
  - Emitted marker, LSB first: [1:0]=2'b10, [9:2]=M0, [17:10]=M1, [25:18]=M2, [33:26]=BIP3, [41:34]=M4, [49:42]=M5, [57:50]=M6, [65:58]=BIP7=~BIP3.
- Marker bytes (M0,M1,M2 / M4,M5,M6):
  - lane0 90,76,47 / 6f,89,b8.
  - lane1 f0,c4,e6 / 0f,3b,19.
  - lane2 c5,65,9b / 3a,9a,64.
  - lane3 a2,79,3d / 5d,86,c2.
- BIP accumulator bip_q[7:0], reset 8'h00. Bit k is the XOR over every emitted block of emitted bits {8j+k+2, j=0..7}.
  - Bit 3 additionally includes bit 0.
  - Bit 4 additionally includes bit 1.
  - This covers all 66 bits, sync header included.
- Data slot: bip_q ^= parity(block_o).
- Marker slot: the marker's BIP3 = bip_q. Then bip_q restarts as parity(emitted marker), with the BIP3/BIP7 fields included.
- valid_i low: no state changes; valid_o=0; block_o holds its previous value.

## Timing
- Latency block_i to block_o: 1 cycle.
- valid_o = valid_i delayed by 1.
- am_v_o = (valid_i & cnt_q==0) delayed by 1.
- Period: exactly 1 marker + GAP_N data blocks per GAP_N+1 valid slots, independent of the valid_i gap pattern.
- Outputs during and after reset:
  - valid_o=0, am_v_o=0, block_o=0 while nreset=0 and in the first cycle after release.
  - ready_o=0 while nreset=0.
  - cnt_q=0, bip_q=0.
- Reset mid-period: discards the partial period. The first valid slot after release emits a marker with BIP3=8'h00, BIP7=8'hff.
- valid_i low in the cycle cnt_q==0: the marker is deferred to the next valid slot. ready_o stays 0 until then.
- Upstream rule: when valid_i & ~ready_o, block_i must be held unchanged into the next valid slot.

## Configuration
- AM_TX_SHORT_GAP_EN:
  - Defined: the effective gap is 31 data blocks regardless of GAP_N (simulation only).
  - Undefined: the gap is GAP_N.
- Marker format, BIP rules and handshake are identical in both builds.

## Test plan
- Reset released, valid_i=1 constant, LANE=0: first valid_o beat has am_v_o=1 and block_o = {8'hff,8'hb8,8'h89,8'h6f,8'h00,8'h47,8'h76,8'h90,2'b10}; ready_o=0 in that input cycle, then 1.
- After the first marker, feed GAP_N blocks with payload 0 and sync header 2'b01:
  - the next marker comes exactly GAP_N+1 valid slots after the first;
  - its BIP3 = parity(first marker) ^ 8'h08;
  - its BIP7 = ~BIP3.
- Random valid_i duty (about 50%) with an incrementing payload: output data equals the input sequence with no loss or duplication. A marker appears after every GAP_N data beats, and BIP3 matches the bench model.
- valid_i=0 exactly when cnt_q==0, for 5 cycles: ready_o stays 0 for 5 cycles. The marker is emitted on the 6th cycle (valid_i=1), and the held block_i appears immediately after it.
- nreset pulsed low for 1 cycle at data slot 1000: outputs are 0 during reset. The next valid beat is a marker with BIP3=8'h00, BIP7=8'hff, and a full GAP_N period follows.
- LANE=3 with AM_TX_SHORT_GAP_EN: markers carry bytes a2,79,3d / 5d,86,c2 and repeat every 32 valid slots.

Source files
------------

// File: rtl/am_insert_tx.sv
// Alignment marker inserter for one 40GBASE-R PCS lane, with BIP3/BIP7 generation.
// Optional build macro AM_TX_SHORT_GAP_EN: forces a 31-block marker gap (simulation only).
module am_insert_tx #(
  parameter int BLOCK_W = 66,
  parameter int LANE    = 0,
  parameter int GAP_N   = 16383
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic               am_v_o
);

`ifdef AM_TX_SHORT_GAP_EN
  localparam int GAP = 31;
`else
  localparam int GAP = GAP_N;
`endif
  localparam int CW = $clog2(GAP + 1);

  // Marker bytes packed as {M0, M1, M2, M4, M5, M6}
  localparam logic [47:0] AM_BYTES =
    (LANE == 0) ? 48'h90_76_47_6f_89_b8 :
    (LANE == 1) ? 48'hf0_c4_e6_0f_3b_19 :
    (LANE == 2) ? 48'hc5_65_9b_3a_9a_64 :
                  48'ha2_79_3d_5d_86_c2;

  logic [CW-1:0]      cnt_q;
  logic [7:0]         bip_q;
  logic [BLOCK_W-1:0] am_blk;
  logic               am_slot;

  // Byte-wise XOR of the payload lanes; sync header folds into bits 3 and 4
  function automatic logic [7:0] parity(input logic [BLOCK_W-1:0] b);
    logic [7:0] p;
    p = {3'b000, b[1], b[0], 3'b000};
    for (int unsigned j = 0; j < 8; j++) begin
      p ^= b[8*j+2 +: 8];
    end
    return p;
  endfunction

  always_comb begin
    am_blk = {~bip_q, AM_BYTES[7:0], AM_BYTES[15:8], AM_BYTES[23:16],
              bip_q, AM_BYTES[31:24], AM_BYTES[39:32], AM_BYTES[47:40], 2'b10};
  end

  assign am_slot = (cnt_q == '0);
  assign ready_o = nreset & ~am_slot;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q   <= '0;
      bip_q   <= '0;
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
      block_o <= '0;
    end else begin
      valid_o <= valid_i;
      am_v_o  <= valid_i & am_slot;
      if (valid_i) begin
        if (am_slot) begin
          block_o <= am_blk;
          bip_q   <= parity(am_blk);
          cnt_q   <= CW'(1);
        end else begin
          block_o <= block_i;
          bip_q   <= bip_q ^ parity(block_i);
          cnt_q   <= (cnt_q == CW'(GAP)) ? '0 : cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_am_insert_tx.sv
// Self-checking bench for am_insert_tx: vector table, reference model and stream checks.
module tb_am_insert_tx;

`ifdef AM_TX_SHORT_GAP_EN
  localparam int GAP  = 31;
  localparam int LANE = 3;
  localparam logic [47:0] LB  = 48'ha2_79_3d_5d_86_c2;
  localparam logic [65:0] MK0 = {8'hff, 8'hc2, 8'h86, 8'h5d, 8'h00, 8'h3d, 8'h79, 8'ha2, 2'b10};
`else
  localparam int GAP  = 16383;
  localparam int LANE = 0;
  localparam logic [47:0] LB  = 48'h90_76_47_6f_89_b8;
  localparam logic [65:0] MK0 = {8'hff, 8'hb8, 8'h89, 8'h6f, 8'h00, 8'h47, 8'h76, 8'h90, 2'b10};
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [65:0] block_i = '0;
  logic        ready_o, valid_o, am_v_o;
  logic [65:0] block_o;

  am_insert_tx #(.BLOCK_W(66), .LANE(LANE), .GAP_N(16383)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .block_i(block_i),
    .ready_o(ready_o), .valid_o(valid_o), .block_o(block_o), .am_v_o(am_v_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_par(input logic [65:0] b);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) begin
      p[k] = 1'b0;
      for (int j = 0; j < 8; j++) p[k] = p[k] ^ b[8*j+k+2];
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [65:0] ref_mk(input logic [7:0] bip);
    return {~bip, LB[7:0], LB[15:8], LB[23:16], bip, LB[31:24], LB[39:32], LB[47:40], 2'b10};
  endfunction

  // reference model state
  int          m_cnt = 0;
  logic [7:0]  m_bip = '0;
  logic [65:0] m_bo  = '0;

  // upstream source and output stream tracking
  logic [65:0] cur_blk = {64'h0, 2'b01};
  bit          src_inc = 0;
  bit          stream_on = 0;
  bit          gap_chk = 0;
  longint      exp_p = 0;
  int          dcount = 0;
  int          markers = 0;

  logic r, vo, am;
  logic [65:0] bo;

  task automatic step(input logic nr, input logic v, input logic [65:0] blk);
    logic e_rdy, e_am;
    @(negedge clk);
    nreset = nr; valid_i = v; block_i = blk;
    #1 r = ready_o;
    @(posedge clk);
    #1 vo = valid_o; am = am_v_o; bo = block_o;
    e_am = 1'b0;
    if (!nr) begin
      e_rdy = 1'b0; m_cnt = 0; m_bip = '0; m_bo = '0;
    end else begin
      e_rdy = (m_cnt != 0);
      if (v) begin
        if (m_cnt == 0) begin
          e_am = 1'b1; m_bo = ref_mk(m_bip); m_bip = ref_par(m_bo); m_cnt = 1;
        end else begin
          m_bo = blk; m_bip = m_bip ^ ref_par(blk);
          m_cnt = (m_cnt == GAP) ? 0 : m_cnt + 1;
        end
      end
    end
    chk("m_ready", 66'(r), 66'(e_rdy));
    chk("m_valid", 66'(vo), 66'(nr & v));
    chk("m_am", 66'(am), 66'(e_am));
    chk("m_block", bo, m_bo);
    if (nr && v && r && src_inc) cur_blk = {cur_blk[65:2] + 64'd1, 2'b01};
    if (stream_on && vo && !am) begin
      chk("stream", bo, {exp_p[63:0], 2'b01});
      exp_p++;
      dcount++;
    end
    if (stream_on && vo && am) begin
      if (gap_chk) chk("gap_len", 66'(dcount), 66'(GAP));
      dcount = 0; gap_chk = 1; markers++;
    end
  endtask

  typedef struct {
    logic nr; logic v; logic [65:0] blk;
    logic e_rdy; logic e_vo; logic e_am; logic [65:0] e_bo;
  } vec_t;

  localparam logic [65:0] B1 = {64'h0123456789abcdef, 2'b01};
  localparam logic [65:0] B2 = {64'hfedcba9876543210, 2'b10};
  localparam logic [65:0] Z1 = {64'h0, 2'b01};

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b0, 1'b1, B1, 1'b0, 1'b0, 1'b0, 66'h0};
    vt[1] = '{1'b0, 1'b1, B1, 1'b0, 1'b0, 1'b0, 66'h0};
    vt[2] = '{1'b1, 1'b1, B1, 1'b0, 1'b1, 1'b1, MK0};
    vt[3] = '{1'b1, 1'b1, B1, 1'b1, 1'b1, 1'b0, B1};
    vt[4] = '{1'b1, 1'b0, B2, 1'b1, 1'b0, 1'b0, B1};
    vt[5] = '{1'b1, 1'b1, B2, 1'b1, 1'b1, 1'b0, B2};
    vt[6] = '{1'b0, 1'b1, Z1, 1'b0, 1'b0, 1'b0, 66'h0};
    vt[7] = '{1'b1, 1'b0, Z1, 1'b0, 1'b0, 1'b0, 66'h0};
    vt[8] = '{1'b1, 1'b1, Z1, 1'b0, 1'b1, 1'b1, MK0};

    for (int i = 0; i < 9; i++) begin
      step(vt[i].nr, vt[i].v, vt[i].blk);
      chk($sformatf("vec%0d_ready", i), 66'(r), 66'(vt[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 66'(vo), 66'(vt[i].e_vo));
      chk($sformatf("vec%0d_am", i), 66'(am), 66'(vt[i].e_am));
      chk($sformatf("vec%0d_block", i), bo, vt[i].e_bo);
    end

    // zero-payload period, then a marker deferred by 5 idle slots
    for (int i = 0; i < GAP; i++) step(1'b1, 1'b1, cur_blk);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, cur_blk);
      chk("stall_ready", 66'(r), 66'(0));
      chk("stall_valid", 66'(vo), 66'(0));
    end
    step(1'b1, 1'b1, cur_blk);
    chk("mk2_am", 66'(am), 66'(1));
    chk("mk2_ready", 66'(r), 66'(0));
    chk("mk2_bip3", 66'(bo[33:26]), 66'(8'h18));
    chk("mk2_bip7", 66'(bo[65:58]), 66'(8'he7));

    // random duty stream; held block must follow the marker directly
    stream_on = 1; src_inc = 1; exp_p = 0; dcount = 0; gap_chk = 1; markers = 0;
    step(1'b1, 1'b1, cur_blk);
    chk("held_block", bo, Z1);
    chk("held_am", 66'(am), 66'(0));
    begin
      int budget;
      budget = 3 * (GAP + 1000) + 200;
      while (!(markers >= 1 && dcount == 1000) && budget > 0) begin
        step(1'b1, 1'($urandom_range(1, 0)), cur_blk);
        budget--;
      end
      chk("random_budget", 66'(budget > 0), 66'(1));
    end

    // reset pulse mid-period
    gap_chk = 0;
    step(1'b0, 1'b1, cur_blk);
    chk("rst_valid", 66'(vo), 66'(0));
    chk("rst_am", 66'(am), 66'(0));
    chk("rst_block", bo, 66'h0);
    chk("rst_ready", 66'(r), 66'(0));
    step(1'b1, 1'b1, cur_blk);
    chk("rmk_am", 66'(am), 66'(1));
    chk("rmk_bip3", 66'(bo[33:26]), 66'(8'h00));
    chk("rmk_bip7", 66'(bo[65:58]), 66'(8'hff));
    chk("rmk_block", bo, MK0);
    for (int i = 0; i <= GAP; i++) step(1'b1, 1'b1, cur_blk);
    chk("period_am", 66'(am), 66'(1));
    chk("period_markers", 66'(markers), 66'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
